data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Responder (memory side) of the processor data-memory port. Serves the core's
//  m_address/m_data/memw_m outputs and returns read data to its input_data.
//  Word-addressed RAM plus a small MMIO window with cycle/store counters and an
//  output register. Sticky error flag for illegal accesses. Sits beside the core.
// PARAMETERS
//  WORDS_LOG2  10              RAM depth = 2**WORDS_LOG2 32-bit words, at byte address 0
//  MMIO_BASE   32'hFFFF_FF00   base byte address of the 4-word MMIO window
// PORTS
//  clk         in   1   clock, all state on rising edge
//  rst         in   1   asynchronous reset, active-low
//  m_address   in   32  byte address from core (MEM stage)
//  m_data      in   32  store data from core
//  memw_m      in   1   store enable from core
//  read_data   out  32  load data to core input_data, registered
//  out_reg     out  32  MMIO output register (LEDs/debug)
//  err         out  1   sticky illegal-access flag
// BEHAVIOUR
//  Reset (rst=0, async): read_data=0, out_reg=0, err=0, cyc_cnt=0, st_cnt=0.
//   RAM contents are not reset. A store in the cycle reset is low is discarded.
//  Decode: RAM hit if m_address < 4*2**WORDS_LOG2; word index = m_address[WORDS_LOG2+1:2].
//   MMIO hit if m_address[31:4]==MMIO_BASE[31:4]. Word offset is m_address[3:2]:
//     0 CYC  RO  cyc_cnt, +1 every cycle out of reset, wraps 32'hFFFF_FFFF->0
//     1 STC  RO  st_cnt, +1 per accepted store (RAM or out_reg), wraps
//     2 OUT  RW  out_reg
//     3 ERR  R/W1C  {31'b0,err}; store with m_data[0]=1 clears err
//   Anything else is unmapped.
//  Loads: no read strobe. Every cycle, read_data <= value at m_address sampled at
//   the same edge (1-cycle latency). Unmapped -> 0.
//  Stores: memw_m=1 at an edge writes m_data at that edge. Stores to RAM or OUT
//   increment st_cnt. Stores to CYC or STC are ignored and set err. Stores to ERR
//   do not count.
//  Same-cycle store+load at one address: write-first; read_data gets m_data.
//   For ERR this returns the post-clear value.
//  Misaligned (m_address[1:0]!=0): bits [1:0] ignored for decode; if memw_m=1,
//   store still performed and err set. Misaligned load does not set err.
//  Unmapped store: no RAM/MMIO change, no st_cnt increment, err set.
//  err: set wins over a W1C clear in the same cycle.
//  CYC read value is the count before that edge's increment.
//  Fully synchronous apart from reset; no combinational path from inputs to outputs.
// TESTING
//  1. Release rst; store 32'h190 to 0x10, load 0x10 next cycle -> read_data=32'h190
//     one cycle after the load address; STC reads 1.
//  2. Same cycle memw_m=1, m_address=0x20, m_data=32'h12C -> read_data=32'h12C
//     next cycle (write-first).
//  3. Store 32'hA5 to MMIO_BASE+8 -> out_reg=32'hA5 next cycle; STC increments;
//     load of MMIO_BASE+8 returns 32'hA5.
//  4. Store to 0x0010_0000 (unmapped) -> err=1, st_cnt unchanged. Store 1 to
//     MMIO_BASE+12 -> err=0. Store to MMIO_BASE+0 -> err=1.
//  5. Store 32'h5 to 0x13 (misaligned) -> word 0x10 holds 5 and err=1.
//  6. Assert rst mid-burst with memw_m=1 -> outputs/counters 0 immediately and
//     the store is lost. After release, CYC load at cycle k returns k-1.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Memory-side responder for the core's data port: word-addressed RAM at byte
//   address 0 plus a 4-word MMIO window (cycle counter, store counter, output
//   register, sticky error flag).
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-low
//   m_address  byte address from the core (MEM stage)
//   m_data     store data from the core
//   memw_m     store enable from the core
//   read_data  registered load data (1-cycle latency, write-first)
//   out_reg    MMIO output register
//   err        sticky illegal-access flag (W1C via the ERR register)
module data_mem_responder #(
  parameter int unsigned WORDS_LOG2 = 10,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] m_address,
  input  logic [31:0] m_data,
  input  logic        memw_m,
  output logic [31:0] read_data,
  output logic [31:0] out_reg,
  output logic        err
);

  typedef enum logic [1:0] {
    REG_CYC = 2'd0,
    REG_STC = 2'd1,
    REG_OUT = 2'd2,
    REG_ERR = 2'd3
  } mmio_reg_e;

  logic [31:0] mem [0:(2**WORDS_LOG2)-1];

  logic [31:0] cyc_cnt;
  logic [31:0] st_cnt;

  logic                  ram_hit;
  logic                  mmio_hit;
  logic                  misaligned;
  logic [WORDS_LOG2-1:0] idx;
  mmio_reg_e             reg_sel;

  logic        ram_we;
  logic        out_we;
  logic        err_set;
  logic        err_clr;
  logic        err_n;
  logic [31:0] rd_n;

  // Address decode ignores bits [1:0]; the RAM occupies everything below
  // 4*2**WORDS_LOG2, i.e. all bits above the word index must be zero.
  assign ram_hit    = ~|m_address[31:WORDS_LOG2+2];
  assign mmio_hit   = (m_address[31:4] == MMIO_BASE[31:4]);
  assign misaligned = |m_address[1:0];
  assign idx        = m_address[WORDS_LOG2+1:2];
  assign reg_sel    = mmio_reg_e'(m_address[3:2]);

  always_comb begin
    ram_we  = 1'b0;
    out_we  = 1'b0;
    err_set = 1'b0;
    err_clr = 1'b0;
    if (memw_m) begin
      if (ram_hit) begin
        ram_we = 1'b1;
      end else if (mmio_hit) begin
        unique case (reg_sel)
          REG_CYC, REG_STC: err_set = 1'b1;
          REG_OUT:          out_we  = 1'b1;
          REG_ERR:          err_clr = m_data[0];
          default:          ;
        endcase
      end else begin
        err_set = 1'b1;
      end
      if (misaligned) err_set = 1'b1;
    end
  end

  // Setting the flag takes priority over a same-cycle W1C clear.
  always_comb begin
    err_n = err;
    if (err_clr) err_n = 1'b0;
    if (err_set) err_n = 1'b1;
  end

  // Load mux sees this edge's store (write-first); CYC returns the pre-increment count.
  always_comb begin
    rd_n = '0;
    if (ram_hit) begin
      rd_n = ram_we ? m_data : mem[idx];
    end else if (mmio_hit) begin
      unique case (reg_sel)
        REG_CYC: rd_n = cyc_cnt;
        REG_STC: rd_n = st_cnt;
        REG_OUT: rd_n = out_we ? m_data : out_reg;
        REG_ERR: rd_n = {31'b0, err_n};
        default: rd_n = '0;
      endcase
    end
  end

  // RAM is not reset, but a store arriving while reset is held is dropped.
  always_ff @(posedge clk) begin
    if (rst && ram_we) mem[idx] <= m_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      read_data <= '0;
      out_reg   <= '0;
      err       <= 1'b0;
      cyc_cnt   <= '0;
      st_cnt    <= '0;
    end else begin
      read_data <= rd_n;
      err       <= err_n;
      cyc_cnt   <= cyc_cnt + 32'd1;
      if (out_we)           out_reg <= m_data;
      if (ram_we || out_we) st_cnt  <= st_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  localparam logic [31:0] MB = 32'hFFFF_FF00;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] m_address = MB + 32'd8;
  logic [31:0] m_data = '0;
  logic        memw_m = 1'b0;
  logic [31:0] read_data;
  logic [31:0] out_reg;
  logic        err;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  bit          chk_en = 1'b0;

  data_mem_responder #(.WORDS_LOG2(10), .MMIO_BASE(MB)) dut (
    .clk(clk), .rst(rst), .m_address(m_address), .m_data(m_data),
    .memw_m(memw_m), .read_data(read_data), .out_reg(out_reg), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain address arithmetic over a word array and counters.
  logic [31:0] m_mem [1024];
  bit          m_vld [1024];
  logic [31:0] m_cyc, m_st, exp_rd, exp_out;
  logic        exp_err;
  bit          exp_rd_known;

  always @(posedge clk or negedge rst) begin : model
    logic [31:0] word, rdv, off;
    logic        in_ram, in_mmio, nerr;
    bit          known;
    if (!rst) begin
      exp_rd <= '0; exp_out <= '0; exp_err <= 1'b0;
      m_cyc <= '0; m_st <= '0; exp_rd_known <= 1'b1;
    end else begin
      word    = {m_address[31:2], 2'b00};
      in_ram  = word < 32'd4096;
      in_mmio = (word >= MB) && (word < MB + 32'd16);
      off     = (word - MB) / 4;
      nerr    = exp_err;
      rdv     = '0;
      known   = 1'b1;
      if (memw_m) begin
        if (in_ram) begin
          m_mem[word / 4] <= m_data;
          m_vld[word / 4] <= 1'b1;
          m_st <= m_st + 1;
        end else if (in_mmio && off == 2) begin
          exp_out <= m_data;
          m_st <= m_st + 1;
        end
        if (in_mmio && off == 3 && m_data[0]) nerr = 1'b0;
        if (m_address[1:0] != 0 || !(in_ram || in_mmio) || (in_mmio && off < 2)) nerr = 1'b1;
      end
      if (in_ram) begin
        if (memw_m) rdv = m_data;
        else if (m_vld[word / 4]) rdv = m_mem[word / 4];
        else known = 1'b0;
      end else if (in_mmio) begin
        case (off)
          0: rdv = m_cyc;
          1: rdv = m_st;
          2: rdv = memw_m ? m_data : exp_out;
          default: rdv = {31'b0, nerr};
        endcase
      end
      exp_rd <= rdv;
      exp_rd_known <= known;
      exp_err <= nerr;
      m_cyc <= m_cyc + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_rd_known) check("model_read_data", read_data, exp_rd);
      check("model_out_reg", out_reg, exp_out);
      check("model_err", {31'b0, err}, {31'b0, exp_err});
    end
  end

  task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic w);
    @(negedge clk);
    m_address = a; m_data = d; memw_m = w;
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_read_data", read_data, 32'h0);
    check("reset_out_reg", out_reg, 32'h0);
    check("reset_err", {31'b0, err}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    chk_en = 1'b1;

    // 1: store then load, STC
    cyc(32'h10, 32'h190, 1'b1);
    cyc(32'h10, 32'h0, 1'b0);
    check("t1_load", read_data, 32'h190);
    cyc(MB + 4, 32'h0, 1'b0);
    check("t1_stc", read_data, 32'h1);

    // 2: write-first
    cyc(32'h20, 32'h12C, 1'b1);
    check("t2_write_first", read_data, 32'h12C);

    // 3: OUT register
    cyc(MB + 8, 32'hA5, 1'b1);
    check("t3_out_reg", out_reg, 32'hA5);
    check("t3_out_wf", read_data, 32'hA5);
    cyc(MB + 4, 32'h0, 1'b0);
    check("t3_stc", read_data, 32'h3);
    cyc(MB + 8, 32'h0, 1'b0);
    check("t3_out_load", read_data, 32'hA5);

    // 4: error flag
    cyc(32'h0010_0000, 32'h1, 1'b1);
    check("t4_unmapped_err", {31'b0, err}, 32'h1);
    check("t4_unmapped_rd", read_data, 32'h0);
    cyc(MB + 4, 32'h0, 1'b0);
    check("t4_stc_unchanged", read_data, 32'h3);
    cyc(MB + 12, 32'h1, 1'b1);
    check("t4_w1c", {31'b0, err}, 32'h0);
    check("t4_w1c_rd", read_data, 32'h0);
    cyc(MB + 0, 32'h7, 1'b1);
    check("t4_ro_store_err", {31'b0, err}, 32'h1);
    cyc(MB + 12, 32'h0, 1'b0);
    check("t4_err_load", read_data, 32'h1);
    cyc(MB + 13, 32'h1, 1'b1);
    check("t4_set_wins", {31'b0, err}, 32'h1);
    cyc(MB + 12, 32'h1, 1'b1);
    check("t4_clear_again", {31'b0, err}, 32'h0);

    // 5: misaligned store
    cyc(32'h13, 32'h5, 1'b1);
    check("t5_mis_err", {31'b0, err}, 32'h1);
    cyc(32'h10, 32'h0, 1'b0);
    check("t5_mis_data", read_data, 32'h5);
    cyc(32'h11, 32'h0, 1'b0);
    check("t5_mis_load", read_data, 32'h5);
    cyc(MB + 4, 32'h0, 1'b0);
    check("t5_stc", read_data, 32'h4);
    cyc(32'h40, 32'h77, 1'b1);

    // 6: reset mid-burst
    @(negedge clk);
    m_address = 32'h40; m_data = 32'hDEAD; memw_m = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("t6_async_rd", read_data, 32'h0);
    check("t6_async_out", out_reg, 32'h0);
    check("t6_async_err", {31'b0, err}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    m_address = MB; m_data = 32'h0; memw_m = 1'b0;
    rst = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      check("t6_cyc", read_data, 32'(k - 1));
    end
    cyc(32'h40, 32'h0, 1'b0);
    check("t6_store_lost", read_data, 32'h77);
    cyc(MB + 4, 32'h0, 1'b0);
    check("t6_stc_reset", read_data, 32'h0);
    cyc(MB + 8, 32'h0, 1'b0);
    check("t6_out_reset", read_data, 32'h0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
